md_issue_ctrl: RTL
==================

// Module: md_issue_ctrl
// PURPOSE
//  EX-stage issue controller sitting directly upstream of the multiply/divide unit (MDU).
//  Decodes the EX instruction into MDU commands (start, md_op, mthi/mtlo) and drives operands.
//  Tracks MDU occupancy with a shadow counter and raises stall_d for MD-class instructions in D
//  (mult*/div*/madd*/msub*/mfhi/mflo/mthi/mtlo).
// PARAMETERS
//  W        32  datapath width of operands
//  MUL_CYC  5   MDU occupancy for mult/multu/madd*/msub*, issue cycle included
//  DIV_CYC  10  MDU occupancy for div/divu, issue cycle included
// PORTS
//  clk        in   1  clock
//  reset      in   1  reset, synchronous, active-high
//  ex_valid   in   1  EX stage holds a live instruction
//  ex_instr   in   32 EX instruction word
//  ex_rs_val  in   W  forwarded rs value in EX
//  ex_rt_val  in   W  forwarded rt value in EX
//  ex_flush   in   1  kill EX instruction this cycle (exception/interrupt)
//  d_instr    in   32 D-stage instruction word, used for stall decision
//  md_busy    in   1  MDU busy, used for assertion cross-check only
//  md_start   out  1  one-cycle launch pulse to MDU
//  md_op      out  3  MDU opcode, md_pkg encoding
//  md_a       out  W  operand A (rs)
//  md_b       out  W  operand B (rt)
//  md_wd      out  W  mthi/mtlo write data (rs)
//  md_mthi    out  1  write HI
//  md_mtlo    out  1  write LO
//  stall_d    out  1  freeze F/D, bubble into EX
// BEHAVIOUR
//  - Decode: SPECIAL funct 18/19/1A/1B -> MULT/MULTU/DIV/DIVU; 10/11/12/13 -> mfhi/mthi/mflo/mtlo.
//    SPECIAL2 (op 1C) funct 00/01/04/05 -> MADD/MADDU/MSUB/MSUBU.
//  - Issue is combinational from EX: md_start = ex_valid & start_class & ~ex_flush & ~occupied.
//    md_mthi/md_mtlo gated the same way, so a flushed op never reaches the MDU.
//  - Shadow counter cnt: on md_start, load MUL_CYC-1 or DIV_CYC-1; else decrement if >0.
//    occupied = (cnt != 0).
//  - stall_d = d_is_md & (occupied | md_start | ex_mt_issue). Non-MD instructions in D never stall.
//  - FSM: IDLE (cnt==0) -> RUN on md_start; RUN -> IDLE when cnt reaches 0.
//    A new start in the cycle cnt hits 0 is legal (back-to-back).
//  - ex_flush while RUN: counter continues; the MDU cannot abort.
//  - Divide by zero: issued normally; no trap, HI/LO contents are whatever the MDU produces.
//  - Reset: cnt=0, buffer empty; all outputs are 0 (md_a/md_b/md_wd follow inputs, gated to 0).
//    Reset mid-op returns to IDLE immediately.
//  - Assertion (sim only): md_busy==1 while cnt==0 and no start in the previous cycle -> $error.
// CONFIGURATION
//  MD_ISSUE_BUFFER_EN defined: adds a 1-entry buffer {op,a,b}.
//    - A start-class EX op arriving while occupied is captured instead of stalling.
//    - The buffered op launches in the first cycle cnt==0. The buffer has priority over a new EX op,
//      and the EX op in that cycle is captured.
//    - stall_d covers only mf*/mt* in D, or a start-class op in D while the buffer is full.
//    - ex_flush never clears a captured entry.
//  Undefined: no buffer; every MD-class op in D stalls while occupied.
// STRUCTURE
//  md_pkg: MDOp codes (MULTU 000, MULT 001, DIVU 010, DIV 011, MADD 100, MSUB 101, MADDU 110,
//    MSUBU 111), opcode/funct constants, default latencies.
//  Sub-module md_occupancy_counter: load/decrement counter producing occupied.
// TESTING
//  1. mult rs=3 rt=-2 in EX, idle -> md_start=1, md_op=001, a=3, b=FFFFFFFE;
//     mflo in D stalls exactly 5 cycles.
//  2. divu 100/7 then mfhi directly behind -> stall_d high 10 cycles; after release, HI reads 2.
//  3. mult with ex_flush=1 -> md_start=0; cnt stays 0; next mfhi does not stall.
//  4. reset at cycle 3 of a div -> cnt=0 next cycle, stall_d=0, md_start=0.
//  5. mthi rs=0xDEADBEEF, idle -> md_mthi=1, md_wd=DEADBEEF, no stall;
//     mthi while occupied -> stall until idle.
//  6. BUFFER_EN: mult then madd back-to-back -> madd captured, no stall;
//     madd md_start 5 cycles after mult; mflo stalls until madd done.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the MDU issue controller: MD opcodes, MIPS opcode/funct constants,
// default occupancy latencies and the EX/D instruction decoder.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULTU = 3'b000,
    MD_MULT  = 3'b001,
    MD_DIVU  = 3'b010,
    MD_DIV   = 3'b011,
    MD_MADD  = 3'b100,
    MD_MSUB  = 3'b101,
    MD_MADDU = 3'b110,
    MD_MSUBU = 3'b111
  } md_op_e;

  typedef enum logic {OCC_IDLE, OCC_RUN} occ_state_e;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [5:0] FN2_MADD  = 6'h00;
  localparam logic [5:0] FN2_MADDU = 6'h01;
  localparam logic [5:0] FN2_MSUB  = 6'h04;
  localparam logic [5:0] FN2_MSUBU = 6'h05;

  localparam int MD_MUL_CYC = 5;
  localparam int MD_DIV_CYC = 10;

  typedef struct packed {
    logic   is_start;  // launches an MDU operation
    logic   is_mf;
    logic   is_mthi;
    logic   is_mtlo;
    md_op_e op;
  } md_dec_t;

  function automatic md_dec_t md_decode(input logic [5:0] opc, input logic [5:0] fn);
    md_dec_t d;
    d = '{is_start: 1'b0, is_mf: 1'b0, is_mthi: 1'b0, is_mtlo: 1'b0, op: MD_MULTU};
    if (opc == OP_SPECIAL) begin
      case (fn)
        FN_MULT:  begin d.is_start = 1'b1; d.op = MD_MULT;  end
        FN_MULTU: begin d.is_start = 1'b1; d.op = MD_MULTU; end
        FN_DIV:   begin d.is_start = 1'b1; d.op = MD_DIV;   end
        FN_DIVU:  begin d.is_start = 1'b1; d.op = MD_DIVU;  end
        FN_MFHI, FN_MFLO: d.is_mf = 1'b1;
        FN_MTHI:  d.is_mthi = 1'b1;
        FN_MTLO:  d.is_mtlo = 1'b1;
        default:  ;
      endcase
    end else if (opc == OP_SPECIAL2) begin
      case (fn)
        FN2_MADD:  begin d.is_start = 1'b1; d.op = MD_MADD;  end
        FN2_MADDU: begin d.is_start = 1'b1; d.op = MD_MADDU; end
        FN2_MSUB:  begin d.is_start = 1'b1; d.op = MD_MSUB;  end
        FN2_MSUBU: begin d.is_start = 1'b1; d.op = MD_MSUBU; end
        default:   ;
      endcase
    end
    return d;
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_occupancy_counter.sv
// Shadow of MDU occupancy: loads the op latency on launch, counts down, and reports occupied
// while the IDLE/RUN FSM is in RUN.
module md_occupancy_counter
  import md_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          occupied
);

  occ_state_e    state;
  logic [CW-1:0] cnt;

  // A load in the cycle cnt reaches zero is the back-to-back case and simply reloads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OCC_IDLE;
      cnt   <= '0;
    end else if (load) begin
      cnt   <= load_val;
      state <= (load_val != '0) ? OCC_RUN : OCC_IDLE;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) state <= OCC_IDLE;
    end
  end

  assign occupied = (state == OCC_RUN);

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller for the multiply/divide unit: launches MDU ops, drives operands and
// stalls MD-class instructions in D. MD_ISSUE_BUFFER_EN adds a 1-entry launch buffer.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int W       = 32,
  parameter int MUL_CYC = MD_MUL_CYC,
  parameter int DIV_CYC = MD_DIV_CYC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ex_valid,
  input  logic [31:0]  ex_instr,
  input  logic [W-1:0] ex_rs_val,
  input  logic [W-1:0] ex_rt_val,
  input  logic         ex_flush,
  input  logic [31:0]  d_instr,
  input  logic         md_busy,
  output logic         md_start,
  output logic [2:0]   md_op,
  output logic [W-1:0] md_a,
  output logic [W-1:0] md_b,
  output logic [W-1:0] md_wd,
  output logic         md_mthi,
  output logic         md_mtlo,
  output logic         stall_d
);

  localparam int MAXC = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  md_dec_t       ex_dec, d_dec;
  logic          ex_live, occupied, start, mt_ok, d_is_mfmt;
  md_op_e        start_op;
  logic [W-1:0]  start_a, start_b;
  logic [CW-1:0] load_val;
  logic          unused_bits;

  assign ex_dec      = md_decode(ex_instr[31:26], ex_instr[5:0]);
  assign d_dec       = md_decode(d_instr[31:26], d_instr[5:0]);
  assign unused_bits = ^{ex_instr[25:6], d_instr[25:6]};
  assign ex_live     = ex_valid & ~ex_flush & ~reset;
  assign d_is_mfmt   = d_dec.is_mf | d_dec.is_mthi | d_dec.is_mtlo;

`ifdef MD_ISSUE_BUFFER_EN
  logic         buf_vld, buf_next, capture;
  md_op_e       buf_op;
  logic [W-1:0] buf_a, buf_b;

  // A pending buffered op must reach the MDU before any HI/LO write from EX.
  assign mt_ok = ex_live & ~occupied & ~buf_vld;

  always_comb begin
    start    = 1'b0;
    capture  = 1'b0;
    start_op = ex_dec.op;
    start_a  = ex_rs_val;
    start_b  = ex_rt_val;
    if (!reset && !occupied && buf_vld) begin
      start    = 1'b1;
      start_op = buf_op;
      start_a  = buf_a;
      start_b  = buf_b;
      capture  = ex_live & ex_dec.is_start;
    end else if (ex_live && ex_dec.is_start) begin
      start   = ~occupied;
      capture = occupied & ~buf_vld;
    end
  end

  assign buf_next = capture | (buf_vld & ~(start & buf_vld));

  // Flush never touches a captured entry: the op was already committed to the MDU queue.
  always_ff @(posedge clk) begin
    if (reset) buf_vld <= 1'b0;
    else       buf_vld <= buf_next;
    if (capture) begin
      buf_op <= ex_dec.op;
      buf_a  <= ex_rs_val;
      buf_b  <= ex_rt_val;
    end
  end

  // A start-class op in D is held back whenever the buffer will still be occupied next cycle.
  assign stall_d = ~reset & ((d_is_mfmt & (occupied | start | md_mthi | md_mtlo | buf_vld)) |
                             (d_dec.is_start & buf_next));
`else
  assign mt_ok    = ex_live & ~occupied;
  assign start    = mt_ok & ex_dec.is_start;
  assign start_op = ex_dec.op;
  assign start_a  = ex_rs_val;
  assign start_b  = ex_rt_val;
  assign stall_d  = ~reset & (d_is_mfmt | d_dec.is_start) & (occupied | start | md_mthi | md_mtlo);
`endif

  assign md_start = start;
  assign md_op    = reset ? 3'b000 : start_op;
  assign md_a     = reset ? '0 : start_a;
  assign md_b     = reset ? '0 : start_b;
  assign md_wd    = reset ? '0 : ex_rs_val;
  assign md_mthi  = mt_ok & ex_dec.is_mthi;
  assign md_mtlo  = mt_ok & ex_dec.is_mtlo;
  assign load_val = md_is_div(start_op) ? CW'(DIV_CYC - 1) : CW'(MUL_CYC - 1);

  md_occupancy_counter #(.CW(CW)) u_occ (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_val (load_val),
    .occupied (occupied)
  );

`ifndef SYNTHESIS
  logic start_q;
  always_ff @(posedge clk) begin
    start_q <= start;
    if (!reset)
      assert (!(md_busy && !occupied && !start_q))
        else $error("md_busy set while issue counter idle");
  end
`endif

endmodule
